// File: rtl/tag_stream_generator.sv
// Synthetic Time Tagger tag source: time-ordered multi-lane tag AXI-Stream with gap, channel
// sequencing, alternating polarity, burst length and back-pressure. TAG_GEN_LFSR_EN adds LFSR lane thinning.
module tag_stream_generator #(
  parameter int          WORD_WIDTH = 4,
  parameter int          CHANNELS   = 3,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [31:0]             gap,
  input  logic [31:0]             burst_len,
  input  logic                    fixed_mode,
  input  logic [4:0]              channel_sel,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [WORD_WIDTH-1:0]   m_axis_tkeep,
  output logic [5*WORD_WIDTH-1:0] m_axis_channel,
  output logic [64*WORD_WIDTH-1:0] m_axis_tagtime,
  output logic [WORD_WIDTH-1:0]   m_axis_rising_edge,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             tag_count
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t      state_reg;
  logic [63:0] time_reg;
  logic [31:0] remaining_reg;
  logic        limited_reg;
  logic [4:0]  rr_reg;
  logic [31:0] toggle_reg;

  logic        handshake, launch, advance, gen_fire;
  logic [63:0] base_time;
  logic [31:0] base_rem, base_toggle, step_gap;
  logic [4:0]  base_rr, fixed_ch;
  logic        base_limited;
  logic [WORD_WIDTH-1:0] lane_mask;

  logic [63:0] time_next;
  logic [31:0] rem_next, toggle_next;
  logic [4:0]  rr_next;
  logic [WORD_WIDTH-1:0] keep_next, rise_next;
  logic [4:0]  lane_ch   [WORD_WIDTH];
  logic [63:0] lane_time [WORD_WIDTH];
  logic [5*WORD_WIDTH-1:0]  chan_next;
  logic [64*WORD_WIDTH-1:0] tagtime_next;
  logic        exhausted;
  logic [32:0] count_sum;

  assign handshake = m_axis_tvalid && m_axis_tready;
  assign launch    = (state_reg == IDLE) && start;
  assign advance   = (state_reg == RUN) && !stop && (!m_axis_tvalid || m_axis_tready);
  assign gen_fire  = launch || advance;
  assign busy      = (state_reg != IDLE);

  // A start generates its first beat from freshly initialised run state in the same cycle.
  assign base_time    = launch ? 64'd0 : time_reg;
  assign base_rem     = launch ? burst_len : remaining_reg;
  assign base_limited = launch ? (burst_len != 32'd0) : limited_reg;
  assign base_rr      = launch ? 5'd0 : rr_reg;
  assign base_toggle  = launch ? '1 : toggle_reg;
  assign step_gap     = (gap == 32'd0) ? 32'd1 : gap;
  assign fixed_ch     = 5'(32'(channel_sel) % CHANNELS);

`ifdef TAG_GEN_LFSR_EN
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  logic [31:0] lfsr_reg, lfsr_base, lfsr_step;

  assign lfsr_base = launch ? LFSR_SEED : lfsr_reg;
  assign lfsr_step = {1'b0, lfsr_base[31:1]} ^ (lfsr_base[0] ? LFSR_TAPS : 32'd0);
  assign lane_mask = lfsr_base[WORD_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg <= LFSR_SEED;
    end else if (gen_fire) begin
      lfsr_reg <= lfsr_step;
    end
  end
`else
  // No LFSR: every lane is eligible; the seed folds away as a constant.
  assign lane_mask = {WORD_WIDTH{1'b1}} | WORD_WIDTH'(LFSR_SEED);
`endif

  always_comb begin
    logic [63:0] t;
    logic [31:0] rem;
    logic [31:0] tg;
    logic [4:0]  rr;
    logic [4:0]  ch;
    t   = base_time;
    rem = base_rem;
    tg  = base_toggle;
    rr  = base_rr;
    ch  = 5'd0;
    keep_next = '0;
    rise_next = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      lane_ch[i]   = 5'd0;
      lane_time[i] = 64'd0;
      if (lane_mask[i] && (!base_limited || rem != 32'd0)) begin
        t  = t + 64'(step_gap);
        ch = fixed_mode ? fixed_ch : rr;
        if (!fixed_mode) begin
          rr = (rr == 5'(CHANNELS - 1)) ? 5'd0 : rr + 5'd1;
        end
        keep_next[i] = 1'b1;
        lane_ch[i]   = ch;
        lane_time[i] = t;
        rise_next[i] = tg[ch];
        tg[ch]       = ~tg[ch];
        if (base_limited) begin
          rem = rem - 32'd1;
        end
      end
    end
    time_next   = t;
    rem_next    = rem;
    toggle_next = tg;
    rr_next     = rr;
  end

  genvar gi;
  generate
    for (gi = 0; gi < WORD_WIDTH; gi++) begin : g_pack
      assign chan_next[gi*5 +: 5]     = lane_ch[gi];
      assign tagtime_next[gi*64 +: 64] = lane_time[gi];
    end
  endgenerate

  assign exhausted = base_limited && (rem_next == 32'd0);
  assign count_sum = {1'b0, tag_count} + 33'($countones(m_axis_tkeep));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= IDLE;
      time_reg           <= 64'd0;
      remaining_reg      <= 32'd0;
      limited_reg        <= 1'b0;
      rr_reg             <= 5'd0;
      toggle_reg         <= '1;
      m_axis_tvalid      <= 1'b0;
      m_axis_tkeep       <= '0;
      m_axis_channel     <= '0;
      m_axis_tagtime     <= '0;
      m_axis_rising_edge <= '0;
      done               <= 1'b0;
      tag_count          <= 32'd0;
    end else begin
      done <= 1'b0;

      if (launch) begin
        tag_count <= 32'd0;
      end else if (handshake) begin
        tag_count <= count_sum[32] ? 32'hFFFF_FFFF : count_sum[31:0];
      end

      if (gen_fire) begin
        time_reg           <= time_next;
        remaining_reg      <= rem_next;
        limited_reg        <= base_limited;
        rr_reg             <= rr_next;
        toggle_reg         <= toggle_next;
        m_axis_tvalid      <= |keep_next;
        m_axis_tkeep       <= keep_next;
        m_axis_channel     <= chan_next;
        m_axis_tagtime     <= tagtime_next;
        m_axis_rising_edge <= rise_next;
      end else if (handshake) begin
        m_axis_tvalid      <= 1'b0;
        m_axis_tkeep       <= '0;
        m_axis_channel     <= '0;
        m_axis_tagtime     <= '0;
        m_axis_rising_edge <= '0;
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= exhausted ? FLUSH : RUN;
          end
        end
        RUN: begin
          if (stop) begin
            if (m_axis_tvalid && !m_axis_tready) begin
              state_reg <= FLUSH;
            end else begin
              state_reg <= IDLE;
              done      <= 1'b1;
            end
          end else if (gen_fire && exhausted) begin
            state_reg <= FLUSH;
          end
        end
        FLUSH: begin
          if (handshake) begin
            state_reg <= IDLE;
            done      <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tag_stream_generator.sv
// Scoreboard bench for tag_stream_generator: directed runs push expected beats, a negedge monitor checks them.
module tb_tag_stream_generator;
  localparam int WW = 2;
  localparam int CH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, stop = 1'b0, fixed_mode = 1'b0, tready = 1'b0;
  logic [31:0] gap = 32'd0, burst_len = 32'd0;
  logic [4:0]  channel_sel = 5'd0;
  logic tvalid, busy, done;
  logic [WW-1:0] tkeep, rising;
  logic [5*WW-1:0] chan;
  logic [64*WW-1:0] tagtime;
  logic [31:0] tag_count;

  typedef struct packed {
    logic [WW-1:0]    keep;
    logic [5*WW-1:0]  ch;
    logic [64*WW-1:0] tt;
    logic [WW-1:0]    rise;
  } beat_t;

  beat_t exp_q[$];
  beat_t cur, held;
  bit    hold_pending = 1'b0;
  int    checks = 0;
  int    errors = 0;
  int    n;

  always #5 clk = ~clk;

  tag_stream_generator #(.WORD_WIDTH(WW), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .gap(gap), .burst_len(burst_len),
    .fixed_mode(fixed_mode), .channel_sel(channel_sel),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tkeep(tkeep),
    .m_axis_channel(chan), .m_axis_tagtime(tagtime), .m_axis_rising_edge(rising),
    .busy(busy), .done(done), .tag_count(tag_count)
  );

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [WW-1:0] k, input logic [4:0] c1, input logic [4:0] c0,
                               input logic [63:0] t1, input logic [63:0] t0, input logic [WW-1:0] r);
    beat_t b;
    b.keep = k;
    b.ch   = {c1, c0};
    b.tt   = {t1, t0};
    b.rise = r;
    return b;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cnt);
    cnt = 0;
    while (!done && cnt < limit) begin
      tick();
      cnt++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=0 expected=1");
    end
  endtask

  // Monitor: compare each accepted beat with the scoreboard and check stability under back-pressure.
  always @(negedge clk) begin
    cur = '{tkeep, chan, tagtime, rising};
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) check("hold_stable", cur, held);
      hold_pending = tvalid && !tready;
      held = cur;
      if (tvalid && tready) begin
        $display("beat keep=%b ch=%h time1=%0d time0=%0d rise=%b", tkeep, chan,
                 tagtime[127:64], tagtime[63:0], rising);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%0h expected=none", cur);
        end else begin
          check("beat", cur, exp_q.pop_front());
        end
      end
      if (done) check("done_after_last_beat", exp_q.size(), 0);
    end
  end

  initial begin
    repeat (2) tick();
    check("reset_outputs", {tvalid, tkeep, chan, tagtime, rising, busy, done, tag_count}, '0);
    rst = 1'b0;
    tick();

    // Round-robin burst of 5 with continuous ready
    gap = 32'd4000; burst_len = 32'd5; tready = 1'b1;
    exp_q.push_back(mk(2'b11, 5'd1, 5'd0, 64'd8000, 64'd4000, 2'b11));
    exp_q.push_back(mk(2'b11, 5'd0, 5'd2, 64'd16000, 64'd12000, 2'b01));
    exp_q.push_back(mk(2'b01, 5'd0, 5'd1, 64'd0, 64'd20000, 2'b00));
    pulse_start();
    check("t1_busy_tvalid_after_start", {busy, tvalid}, 2'b11);
    wait_done(20, n);
    check("t1_done_latency", n, 3);
    check("t1_tag_count", tag_count, 32'd5);
    check("t1_idle_after_done", {busy, tvalid}, 2'b00);
    tick();
    check("t1_done_one_cycle", done, 1'b0);

    // Same run with ready toggling and a start pulse while busy
    exp_q.push_back(mk(2'b11, 5'd1, 5'd0, 64'd8000, 64'd4000, 2'b11));
    exp_q.push_back(mk(2'b11, 5'd0, 5'd2, 64'd16000, 64'd12000, 2'b01));
    exp_q.push_back(mk(2'b01, 5'd0, 5'd1, 64'd0, 64'd20000, 2'b00));
    pulse_start();
    n = 0;
    while (!done && n < 40) begin
      tready = ~tready;
      start = (n == 1);
      tick();
      n++;
    end
    start = 1'b0;
    check("t2_done_seen", done, 1'b1);
    check("t2_tag_count", tag_count, 32'd5);
    tready = 1'b1;
    tick();

    // Fixed channel, sel 4 wraps to channel 1
    fixed_mode = 1'b1; channel_sel = 5'd4; gap = 32'd10; burst_len = 32'd4;
    exp_q.push_back(mk(2'b11, 5'd1, 5'd1, 64'd20, 64'd10, 2'b01));
    exp_q.push_back(mk(2'b11, 5'd1, 5'd1, 64'd40, 64'd30, 2'b01));
    pulse_start();
    wait_done(20, n);
    check("t3_done_latency", n, 2);
    check("t3_tag_count", tag_count, 32'd4);
    fixed_mode = 1'b0;
    tick();

    // gap 0 as 1, unlimited, stop under back-pressure goes through FLUSH
    gap = 32'd0; burst_len = 32'd0; tready = 1'b1;
    exp_q.push_back(mk(2'b11, 5'd1, 5'd0, 64'd2, 64'd1, 2'b11));
    exp_q.push_back(mk(2'b11, 5'd0, 5'd2, 64'd4, 64'd3, 2'b01));
    exp_q.push_back(mk(2'b11, 5'd2, 5'd1, 64'd6, 64'd5, 2'b00));
    pulse_start();
    tick();
    tick();
    tready = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t4_flush_holding", {busy, tvalid}, 2'b11);
    tick();
    tick();
    check("t4_flush_no_done", {busy, done}, 2'b10);
    tready = 1'b1;
    wait_done(20, n);
    check("t4_done_latency", n, 1);
    check("t4_tag_count", tag_count, 32'd6);
    tick();

    // Asynchronous reset mid-run, then clean restart
    gap = 32'd7; burst_len = 32'd0; tready = 1'b0;
    pulse_start();
    check("t5_presented_time", tagtime[63:0], 64'd7);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_reset", {tvalid, tkeep, chan, tagtime, rising, busy, done, tag_count}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_no_done_on_reset", {done, busy}, 2'b00);
    tick();
    burst_len = 32'd2; tready = 1'b1;
    exp_q.push_back(mk(2'b11, 5'd1, 5'd0, 64'd14, 64'd7, 2'b11));
    pulse_start();
    wait_done(20, n);
    check("t5_restart_done_latency", n, 1);
    check("t5_restart_tag_count", tag_count, 32'd2);
    tick();

`ifdef TAG_GEN_LFSR_EN
    begin
      logic [31:0] lfsr, rem, tg;
      logic [63:0] t;
      logic [4:0]  rr;
      beat_t b;
      lfsr = 32'hACE1_2468; rem = 32'd100; t = 64'd0; rr = 5'd0; tg = '1;
      while (rem != 0) begin
        b = '0;
        for (int i = 0; i < WW; i++) begin
          if (lfsr[i] && rem != 0) begin
            t = t + 64'd3;
            b.keep[i] = 1'b1;
            b.ch[i*5 +: 5] = rr;
            b.tt[i*64 +: 64] = t;
            b.rise[i] = tg[rr];
            tg[rr] = ~tg[rr];
            rr = (rr == 5'd2) ? 5'd0 : rr + 5'd1;
            rem = rem - 32'd1;
          end
        end
        if (b.keep != '0) exp_q.push_back(b);
        lfsr = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'd0);
      end
    end
    gap = 32'd3; burst_len = 32'd100; tready = 1'b1;
    pulse_start();
    wait_done(400, n);
    check("lfsr_tag_count", tag_count, 32'd100);
    tick();
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
